maxpool2_flatten: RTL
=====================

Name: maxpool2_flatten

Overview:
- Streaming 2x2/stride-2 signed max-pool plus flatten stage. It sits directly upstream of the dense classifier layer.
- Consumes conv/activation pixels in raster order, channel-major: all of channel 0, then channel 1, and so on.
- Emits the pooled feature vector in flattened order. Flattened index = ch*(IMG_H/2)*(IMG_W/2) + prow*(IMG_W/2) + pcol.
- Default geometry gives 16 x 10 x 10 = 1600 features, matching the dense layer's 1600-entry 12-bit input vector.

Parameters:
DATA_W, 12, signed pixel/feature width
IMG_W, 20, input map width; must be even
IMG_H, 20, input map height; must be even
CHANNELS, 16, number of maps per frame
IDX_W, 11, width of out_index; must satisfy 2^IDX_W >= CHANNELS*IMG_W*IMG_H/4

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  input pixel valid
in_ready  out  1  stage can accept a pixel
in_data  in  DATA_W  signed pixel
out_valid  out  1  pooled feature valid
out_ready  in  1  downstream accepts feature
out_data  out  DATA_W  signed pooled max
out_index  out  IDX_W  flattened feature index
out_last  out  1  high with the final feature of the frame
frame_done  out  1  one-cycle pulse after the last feature is accepted

Behaviour:
- Reset (rst high at a clk edge), regardless of current state:
  - out_valid=0, out_last=0, frame_done=0, out_data=0, out_index=0.
  - Column, row, channel and index counters cleared.
  - Line buffer contents are don't-care.
  - in_ready=1 on the first cycle after reset.
  - Reset mid-frame discards all partial pooling state; the next accepted pixel is treated as (ch0, row0, col0).
- Transfers:
  - Input transfer = in_valid && in_ready.
  - Output transfer = out_valid && out_ready.
  - in_ready = !out_valid || out_ready. This is a single output register with no bubble on continuous flow.
- Counters:
  - col advances on each input transfer.
  - col wraps IMG_W-1 -> 0 and increments row.
  - row wraps IMG_H-1 -> 0 and increments ch.
  - ch wraps CHANNELS-1 -> 0, ready for the next frame.
- Horizontal pair:
  - On even col, register hold = in_data.
  - On odd col, pair = signed max(hold, in_data).
- Even row, odd col: linebuf[col>>1] <= pair. The line buffer holds IMG_W/2 entries of DATA_W.
- Odd row, odd col:
  - Result = signed max(linebuf[col>>1], pair).
  - Result loads out_data on that same edge and out_valid goes to 1. Latency is one cycle after the completing pixel.
  - out_index = running feature counter, which increments on every output load and resets to 0 after the last feature.
  - out_last = 1 when out_index == CHANNELS*IMG_H*IMG_W/4 - 1.
- Simultaneous output transfer and new result load in the same cycle: out_valid stays 1 with the new data.
- Output transfer with no new result: out_valid goes to 0.
- Output holds stable (data, index, last) while out_valid && !out_ready.
- frame_done pulses exactly one cycle, on the cycle after the out_last transfer. It does not repeat.
- Comparisons are two's-complement signed. Ties choose either value; the result is identical.
- No arithmetic beyond compare, so no overflow cases.
- Back-pressure stalls the input only; an input pixel is never dropped or duplicated.

Test Plan:
- Ramp frame: pixel = (row*IMG_W+col) mod 2048 for one channel -> feature k = pixel at (2*prow+1, 2*pcol+1). Expect 100 outputs per channel and 1600 total, out_index 0..1599, out_last only at 1599, frame_done one pulse.
- Signed values: 2x2 block {-5, -2048, -1, -7} -> out_data = -1. Block {2047, -2048, 0, 0} -> out_data = 2047.
- Back-pressure: hold out_ready low for 10 cycles with in_valid high -> at most one pending output held stable, in_ready low, no lost or duplicated features vs. the reference model. Also toggle out_ready randomly at 50% -> same result.
- Continuous flow: in_valid and out_ready permanently high -> in_ready never drops; each output appears one cycle after its odd-row/odd-col pixel.
- Reset mid-frame: assert rst after 437 accepted pixels -> out_valid=0 next cycle. A fresh full frame then yields indices restarting at 0 and correct maxima.
- Back-to-back frames: two frames with no gap -> second frame's out_index restarts at 0; frame_done pulses twice.

Source files
------------

// File: rtl/maxpool2_flatten.sv
// Streaming 2x2 stride-2 signed max-pool with flattened channel-major output.
// One output register; the line buffer keeps the even-row pair maxima.
module maxpool2_flatten #(
  parameter int DATA_W   = 12,
  parameter int IMG_W    = 20,
  parameter int IMG_H    = 20,
  parameter int CHANNELS = 16,
  parameter int IDX_W    = 11
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]         out_index,
  output logic                     out_last,
  output logic                     frame_done
);

  localparam int HALF_W = IMG_W / 2;
  localparam int COL_W  = (IMG_W > 2) ? $clog2(IMG_W) : 2;
  localparam int ROW_W  = (IMG_H > 2) ? $clog2(IMG_H) : 1;
  localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int NFEAT  = CHANNELS * IMG_H * IMG_W / 4;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CHANNELS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NFEAT - 1);
  localparam logic [COL_W-1:0] COL_ONE  = {{(COL_W-1){1'b0}}, 1'b1};
  localparam logic [ROW_W-1:0] ROW_ONE  = {{(ROW_W-1){1'b0}}, 1'b1};
  localparam logic [CH_W-1:0]  CH_ONE   = {{(CH_W-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};

  function automatic logic signed [DATA_W-1:0] smax(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  logic [COL_W-1:0]         col_r;
  logic [ROW_W-1:0]         row_r;
  logic [CH_W-1:0]          ch_r;
  logic [IDX_W-1:0]         feat_r;
  logic signed [DATA_W-1:0] hold_r;
  logic signed [DATA_W-1:0] linebuf_r [HALF_W];
  logic                     out_valid_r;
  logic signed [DATA_W-1:0] out_data_r;
  logic [IDX_W-1:0]         out_index_r;
  logic                     out_last_r;
  logic                     frame_done_r;

  logic                     in_fire_s;
  logic                     out_fire_s;
  logic                     load_s;
  logic [COL_W-2:0]         lb_idx_s;
  logic signed [DATA_W-1:0] pair_s;
  logic signed [DATA_W-1:0] pool_s;

  // Skid-free handshake: a new result may replace the register only as it leaves.
  assign in_ready   = !out_valid_r || out_ready;
  assign out_valid  = out_valid_r;
  assign out_data   = out_data_r;
  assign out_index  = out_index_r;
  assign out_last   = out_last_r;
  assign frame_done = frame_done_r;

  // Transfer qualifiers and the pooling datapath.
  always_comb begin
    in_fire_s  = in_valid && in_ready;
    out_fire_s = out_valid_r && out_ready;
    lb_idx_s   = col_r[COL_W-1:1];
    pair_s     = smax(hold_r, in_data);
    pool_s     = smax(linebuf_r[lb_idx_s], pair_s);
    load_s     = in_fire_s && col_r[0] && row_r[0];
  end

  // Raster counters, horizontal hold register and the output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_r        <= {COL_W{1'b0}};
      row_r        <= {ROW_W{1'b0}};
      ch_r         <= {CH_W{1'b0}};
      feat_r       <= {IDX_W{1'b0}};
      hold_r       <= {DATA_W{1'b0}};
      out_valid_r  <= 1'b0;
      out_data_r   <= {DATA_W{1'b0}};
      out_index_r  <= {IDX_W{1'b0}};
      out_last_r   <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= out_fire_s && out_last_r;

      if (in_fire_s) begin
        if (!col_r[0]) begin
          hold_r <= in_data;
        end
        if (col_r == COL_LAST) begin
          col_r <= {COL_W{1'b0}};
          if (row_r == ROW_LAST) begin
            row_r <= {ROW_W{1'b0}};
            ch_r  <= (ch_r == CH_LAST) ? {CH_W{1'b0}} : ch_r + CH_ONE;
          end else begin
            row_r <= row_r + ROW_ONE;
          end
        end else begin
          col_r <= col_r + COL_ONE;
        end
      end

      if (load_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= pool_s;
        out_index_r <= feat_r;
        out_last_r  <= (feat_r == IDX_LAST);
        feat_r      <= (feat_r == IDX_LAST) ? {IDX_W{1'b0}} : feat_r + IDX_ONE;
      end else if (out_fire_s) begin
        out_valid_r <= 1'b0;
        out_last_r  <= 1'b0;
      end
    end
  end

  // Line buffer: even-row pair maxima, consumed by the odd row below.
  always_ff @(posedge clk) begin
    if (in_fire_s && col_r[0] && !row_r[0]) begin
      linebuf_r[lb_idx_s] <= pair_s;
    end
  end

endmodule
